// File: rtl/cpu_debug_pkg.sv
// Shared constants for the CPU debug slave: default widths, action bit and IR codes.
package cpu_debug_pkg;

    localparam int DR_W_DEF        = 38;
    localparam int IR_W_DEF        = 2;
    localparam int ACT_BIT_DEF     = 37;
    localparam int NUM_CH_DEF      = 4;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int CNT_W_DEF       = 16;

    typedef enum logic [1:0] {
        IR_OCIMEM    = 2'd0,
        IR_TRACE     = 2'd1,
        IR_BREAK     = 2'd2,
        IR_TRACECTRL = 2'd3
    } ir_code_e;

endpackage

// File: rtl/cpu_debug_edge_sync.sv
// Multi-flop synchroniser for a TCK-domain strobe level, with priming after reset
// and a registered single-cycle rising-edge pulse in the clk domain.
module cpu_debug_edge_sync
    import cpu_debug_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic strobe_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES:0]   prime_q, prime_d;
    logic                   hist_q, hist_d;
    logic                   rise_q, rise_d;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    // The chain restarts from zero, so edge detection is held off until the history
    // flop holds a live sample; a strobe already high at release never looks like an edge.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], strobe_i};
        prime_d = {prime_q[SYNC_STAGES-1:0], 1'b1};
        hist_d  = synced;
        rise_d  = prime_q[SYNC_STAGES] & synced & ~hist_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q  <= '0;
            prime_q <= '0;
            hist_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            prime_q <= prime_d;
            hist_q  <= hist_d;
            rise_q  <= rise_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/cpu_debug_slave_cmd_sync.sv
// System-clock half of the CPU debug slave: synchronises JTAG update strobes and turns
// captured DR/IR values into per-channel take_action / take_no_action commands.
module cpu_debug_slave_cmd_sync
    import cpu_debug_pkg::*;
#(
    parameter int DR_W        = DR_W_DEF,
    parameter int IR_W        = IR_W_DEF,
    parameter int NUM_CH      = NUM_CH_DEF,
    parameter int ACT_BIT     = ACT_BIT_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IR_W-1:0]   ir_in,
    input  logic              vs_uir,
    input  logic              vs_udr,
    input  logic [DR_W-1:0]   sr,
    input  logic              act_ready,
    input  logic              overrun_clr,
    output logic [DR_W-1:0]   jdo,
    output logic              act_valid,
    output logic [IR_W-1:0]   act_ir,
    output logic [NUM_CH-1:0] take_action,
    output logic [NUM_CH-1:0] take_no_action,
    output logic              illegal_ir,
    output logic              overrun,
    output logic [CNT_W-1:0]  cmd_count
);

    logic              uir_rise, udr_rise;
    logic [IR_W-1:0]   ir_reg_q, ir_reg_d;
    logic [DR_W-1:0]   jdo_q, jdo_d;
    logic [IR_W-1:0]   act_ir_q, act_ir_d;
    logic              act_valid_q, act_valid_d;
    logic              overrun_q, overrun_d;
    logic [CNT_W-1:0]  cmd_count_q, cmd_count_d;
    logic              accept, legal, load, ovr_set;

    cpu_debug_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
        .clk_i    (clk),
        .reset_i  (reset),
        .strobe_i (vs_uir),
        .rise_o   (uir_rise)
    );

    cpu_debug_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
        .clk_i    (clk),
        .reset_i  (reset),
        .strobe_i (vs_udr),
        .rise_o   (udr_rise)
    );

    assign accept = act_valid_q & act_ready;
    assign legal  = {1'b0, act_ir_q} < (IR_W+1)'(NUM_CH);

    // A new DR capture only loads into an empty slot or one being drained this cycle;
    // otherwise it is dropped and flagged, so TCK data is sampled only on synced edges.
    always_comb begin
        load        = udr_rise & (~act_valid_q | accept);
        ovr_set     = udr_rise & act_valid_q & ~accept;
        ir_reg_d    = uir_rise ? ir_in : ir_reg_q;
        jdo_d       = load ? sr : jdo_q;
        act_ir_d    = load ? (uir_rise ? ir_in : ir_reg_q) : act_ir_q;
        act_valid_d = load ? 1'b1 : (accept ? 1'b0 : act_valid_q);
        overrun_d   = ovr_set ? 1'b1 : (overrun_clr ? 1'b0 : overrun_q);
        cmd_count_d = cmd_count_q + CNT_W'(accept & legal);
    end

    always_comb begin
        take_action    = '0;
        take_no_action = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (accept && act_ir_q == IR_W'(c)) begin
                take_action[c]    = jdo_q[ACT_BIT];
                take_no_action[c] = ~jdo_q[ACT_BIT];
            end
        end
        illegal_ir = accept & ~legal;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ir_reg_q    <= '0;
            jdo_q       <= '0;
            act_ir_q    <= '0;
            act_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            cmd_count_q <= '0;
        end else begin
            ir_reg_q    <= ir_reg_d;
            jdo_q       <= jdo_d;
            act_ir_q    <= act_ir_d;
            act_valid_q <= act_valid_d;
            overrun_q   <= overrun_d;
            cmd_count_q <= cmd_count_d;
        end
    end

    assign jdo       = jdo_q;
    assign act_ir    = act_ir_q;
    assign act_valid = act_valid_q;
    assign overrun   = overrun_q;
    assign cmd_count = cmd_count_q;

endmodule

// File: tb/tb_cpu_debug_slave_cmd_sync.sv
// Bench for cpu_debug_slave_cmd_sync: two parameterisations driven in parallel against
// a cycle-level behavioural model, plus directed literal expectations.
module tb_cpu_debug_slave_cmd_sync;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  ir_in = '0;
    logic        vs_uir = 1'b0;
    logic        vs_udr = 1'b0;
    logic [37:0] sr = '0;
    logic        act_ready = 1'b0;
    logic        overrun_clr = 1'b0;

    logic [37:0] jdo0, jdo1;
    logic        act_valid0, act_valid1, ill0, ill1, ovr0, ovr1;
    logic [1:0]  air0, air1;
    logic [3:0]  ta0, tna0;
    logic [2:0]  ta1, tna1;
    logic [15:0] cnt0;
    logic [3:0]  cnt1;

    int checks = 0;
    int failures = 0;
    int n_ill1 = 0;
    int n_take1 = 0;

    always #5 clk = ~clk;

    cpu_debug_slave_cmd_sync dut0 (
        .clk(clk), .reset(reset), .ir_in(ir_in), .vs_uir(vs_uir), .vs_udr(vs_udr),
        .sr(sr), .act_ready(act_ready), .overrun_clr(overrun_clr), .jdo(jdo0),
        .act_valid(act_valid0), .act_ir(air0), .take_action(ta0), .take_no_action(tna0),
        .illegal_ir(ill0), .overrun(ovr0), .cmd_count(cnt0)
    );

    cpu_debug_slave_cmd_sync #(.NUM_CH(3), .CNT_W(4), .SYNC_STAGES(3)) dut1 (
        .clk(clk), .reset(reset), .ir_in(ir_in), .vs_uir(vs_uir), .vs_udr(vs_udr),
        .sr(sr), .act_ready(act_ready), .overrun_clr(overrun_clr), .jdo(jdo1),
        .act_valid(act_valid1), .act_ir(air1), .take_action(ta1), .take_no_action(tna1),
        .illegal_ir(ill1), .overrun(ovr1), .cmd_count(cnt1)
    );

    logic [63:0] o_valid[2], o_jdo[2], o_air[2], o_ta[2], o_tna[2], o_ill[2], o_ovr[2], o_cnt[2];
    assign o_valid[0] = 64'(act_valid0);  assign o_valid[1] = 64'(act_valid1);
    assign o_jdo[0]   = 64'(jdo0);        assign o_jdo[1]   = 64'(jdo1);
    assign o_air[0]   = 64'(air0);        assign o_air[1]   = 64'(air1);
    assign o_ta[0]    = 64'(ta0);         assign o_ta[1]    = 64'(ta1);
    assign o_tna[0]   = 64'(tna0);        assign o_tna[1]   = 64'(tna1);
    assign o_ill[0]   = 64'(ill0);        assign o_ill[1]   = 64'(ill1);
    assign o_ovr[0]   = 64'(ovr0);        assign o_ovr[1]   = 64'(ovr1);
    assign o_cnt[0]   = 64'(cnt0);        assign o_cnt[1]   = 64'(cnt1);

    function automatic int nc(input int i); return (i == 0) ? 4 : 3; endfunction
    function automatic int cw(input int i); return (i == 0) ? 16 : 4; endfunction
    function automatic int ss(input int i); return (i == 0) ? 2 : 3; endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state: the pending command of each instance plus the sampled strobe history.
    logic [37:0] m_jdo[2];
    logic [1:0]  m_air[2], m_irr[2];
    bit          m_valid[2], m_ovr[2];
    int          m_cnt[2], m_k[2];
    logic [15:0] m_uh[2], m_dh[2];

    task automatic clear_model(input int i);
        m_jdo[i] = '0; m_air[i] = '0; m_irr[i] = '0; m_valid[i] = 0; m_ovr[i] = 0;
        m_cnt[i] = 0; m_k[i] = 0; m_uh[i] = '0; m_dh[i] = '0;
    endtask

    // Advance the model across the coming posedge, using the inputs that edge will sample.
    // A strobe edge takes effect S+2 edges after the edge that first samples it high,
    // and only once at least S+3 edges have elapsed since reset release.
    task automatic step_model();
        bit acc, legal, uev, dev;
        int s;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                clear_model(i);
            end else begin
                s     = ss(i);
                acc   = m_valid[i] && act_ready;
                legal = int'(m_air[i]) < nc(i);
                if (m_k[i] < 1000) m_k[i]++;
                m_uh[i] = {m_uh[i][14:0], vs_uir};
                m_dh[i] = {m_dh[i][14:0], vs_udr};
                uev = (m_k[i] >= s + 3) && m_uh[i][s+1] && !m_uh[i][s+2];
                dev = (m_k[i] >= s + 3) && m_dh[i][s+1] && !m_dh[i][s+2];
                if (acc && legal) m_cnt[i] = (m_cnt[i] + 1) % (1 << cw(i));
                if (dev && m_valid[i] && !acc) m_ovr[i] = 1;
                else if (overrun_clr) m_ovr[i] = 0;
                if (dev && (!m_valid[i] || acc)) begin
                    m_jdo[i]   = sr;
                    m_air[i]   = uev ? ir_in : m_irr[i];
                    m_valid[i] = 1;
                end else if (acc) begin
                    m_valid[i] = 0;
                end
                if (uev) m_irr[i] = ir_in;
            end
        end
    endtask

    initial begin
        bit          acc, legal;
        logic [63:0] e_ta, e_tna;
        for (int i = 0; i < 2; i++) clear_model(i);
        forever begin
            @(negedge clk);
            if (ill1) n_ill1++;
            if ((ta1 | tna1) != 3'b000) n_take1++;
            for (int i = 0; i < 2; i++) begin
                acc   = m_valid[i] && act_ready;
                legal = int'(m_air[i]) < nc(i);
                e_ta  = (acc && legal && m_jdo[i][37])  ? (64'd1 << m_air[i]) : 64'd0;
                e_tna = (acc && legal && !m_jdo[i][37]) ? (64'd1 << m_air[i]) : 64'd0;
                chk($sformatf("act_valid%0d", i), o_valid[i], 64'(m_valid[i]));
                chk($sformatf("jdo%0d", i), o_jdo[i], 64'(m_jdo[i]));
                chk($sformatf("act_ir%0d", i), o_air[i], 64'(m_air[i]));
                chk($sformatf("take_action%0d", i), o_ta[i], e_ta);
                chk($sformatf("take_no_action%0d", i), o_tna[i], e_tna);
                chk($sformatf("illegal_ir%0d", i), o_ill[i], 64'(acc && !legal));
                chk($sformatf("overrun%0d", i), o_ovr[i], 64'(m_ovr[i]));
                chk($sformatf("cmd_count%0d", i), o_cnt[i], 64'(m_cnt[i]));
            end
            step_model();
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_uir(input logic [1:0] code);
        ir_in = code; vs_uir = 1'b1; step(8);
        vs_uir = 1'b0; step(8);
    endtask

    task automatic pulse_udr(input logic [37:0] data);
        sr = data; vs_udr = 1'b1; step(8);
        vs_udr = 1'b0; step(8);
    endtask

    initial begin
        int ill_before, take_before;
        logic [3:0] c1_before;
        // Strobe already high across reset release must not create a command.
        vs_udr = 1'b1;
        step(5);
        chk("reset_valid", 64'(act_valid0), 64'd0);
        chk("reset_count", 64'(cnt0), 64'd0);
        chk("reset_jdo", 64'(jdo0), 64'd0);
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step(1);
            chk("prime_valid0", 64'(act_valid0), 64'd0);
            chk("prime_valid1", 64'(act_valid1), 64'd0);
        end
        chk("prime_count0", 64'(cnt0), 64'd0);
        vs_udr = 1'b0;
        step(10);

        // Basic action on channel 2, latency SYNC_STAGES+2 = 4 edges.
        act_ready = 1'b1;
        pulse_uir(2'd2);
        sr = 38'h20_0000_00AB; vs_udr = 1'b1;
        step(3);
        chk("lat_not_yet", 64'(act_valid0), 64'd0);
        step(1);
        chk("lat_valid", 64'(act_valid0), 64'd1);
        chk("basic_take_action", 64'(ta0), 64'h4);
        chk("basic_jdo", 64'(jdo0), 64'h20_0000_00AB);
        step(1);
        chk("basic_done", 64'(act_valid0), 64'd0);
        chk("basic_pulse_end", 64'(ta0), 64'd0);
        chk("basic_count", 64'(cnt0), 64'd1);
        step(6); vs_udr = 1'b0; step(8);

        // Backpressure: held command, single no-action pulse when ready rises.
        act_ready = 1'b0;
        pulse_udr(38'h00_1234_5678);
        for (int c = 0; c < 10; c++) begin
            step(1);
            chk("hold_valid", 64'(act_valid0), 64'd1);
            chk("hold_jdo", 64'(jdo0), 64'h00_1234_5678);
            chk("hold_no_pulse", 64'(tna0), 64'd0);
        end
        act_ready = 1'b1; #1;
        chk("bp_take_no_action", 64'(tna0), 64'h4);
        chk("bp_take_action", 64'(ta0), 64'd0);
        step(1);
        chk("bp_done", 64'(act_valid0), 64'd0);
        chk("bp_count", 64'(cnt0), 64'd2);

        // Overrun: second capture dropped while first is still pending.
        act_ready = 1'b0;
        pulse_udr(38'h15_5555_5555);
        pulse_udr(38'h2A_AAAA_AAAA);
        chk("ovr_jdo", 64'(jdo0), 64'h15_5555_5555);
        chk("ovr_flag", 64'(ovr0), 64'd1);
        overrun_clr = 1'b1; step(1); overrun_clr = 1'b0;
        chk("ovr_cleared", 64'(ovr0), 64'd0);
        chk("ovr_still_valid", 64'(act_valid0), 64'd1);
        act_ready = 1'b1; step(1); act_ready = 1'b0;
        step(3);
        chk("ovr_drained", 64'(act_valid0), 64'd0);

        // Accept of the old command in the same cycle as the next capture.
        pulse_udr(38'h01_0000_0A2A);
        sr = 38'h22_0000_0B2B; vs_udr = 1'b1;
        step(3);
        act_ready = 1'b1; step(1); act_ready = 1'b0;
        chk("same_cycle_valid", 64'(act_valid0), 64'd1);
        chk("same_cycle_jdo", 64'(jdo0), 64'h22_0000_0B2B);
        chk("same_cycle_ovr", 64'(ovr0), 64'd0);
        chk("same_cycle_count", 64'(cnt0), 64'd4);
        step(7); vs_udr = 1'b0; step(8);
        act_ready = 1'b1; step(1); act_ready = 1'b0;
        overrun_clr = 1'b1; step(1); overrun_clr = 1'b0;
        step(2);

        // Illegal IR on the 3-channel instance.
        pulse_uir(2'd3);
        ill_before = n_ill1; take_before = n_take1; c1_before = cnt1;
        act_ready = 1'b1;
        pulse_udr(38'h20_0000_0001);
        chk("illegal_pulses", 64'(n_ill1 - ill_before), 64'd1);
        chk("illegal_no_take", 64'(n_take1 - take_before), 64'd0);
        chk("illegal_count", 64'(cnt1), 64'(c1_before));

        // Counter wrap on the 4-bit instance after a fresh reset.
        reset = 1'b1; step(3); reset = 1'b0; step(10);
        pulse_uir(2'd1);
        for (int c = 0; c < 16; c++) begin
            pulse_udr(38'({$urandom, $urandom}));
            if (c == 14) chk("wrap_pre", 64'(cnt1), 64'd15);
        end
        chk("wrap_cnt1", 64'(cnt1), 64'd0);
        chk("wrap_cnt0", 64'(cnt0), 64'd16);

        // Reset while a command is pending.
        act_ready = 1'b0;
        pulse_udr(38'h3F_FFFF_FFFF);
        chk("mid_pending", 64'(act_valid0), 64'd1);
        reset = 1'b1; step(1);
        chk("mid_reset_valid", 64'(act_valid0), 64'd0);
        chk("mid_reset_jdo", 64'(jdo0), 64'd0);
        reset = 1'b0; step(20);
        chk("mid_after", 64'(act_valid0), 64'd0);

        // Randomised traffic, checked cycle by cycle against the model.
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(3) == 0) vs_uir = ~vs_uir;
            else if (!vs_uir) ir_in = 2'($urandom);
            if ($urandom_range(3) == 0) vs_udr = ~vs_udr;
            else if (!vs_udr) sr = 38'({$urandom, $urandom});
            act_ready   = ($urandom_range(2) != 0);
            overrun_clr = ($urandom_range(15) == 0);
            step(1);
        end
        vs_uir = 1'b0; vs_udr = 1'b0; act_ready = 1'b1; overrun_clr = 1'b0;
        step(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
